sram_arbiter: RTL and testbench

- Sequences every access to the single external 1Mx16 SRAM and shares it between two requesters: port 0, the CPU memory path (MAR/MDR side of Mem2IO), and port 1, the debug/program loader.
- Converts a simple req/ack handshake into correctly timed active-low SRAM strobes, with programmable wait states.
- Drives the enable of the 16-bit tristate buffer on the Data bus.
- Arbitration is round-robin, so neither port can starve the other.

---
 rtl/sram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a 1Mx16 asynchronous SRAM.
// Every output is a register loaded from the next-state decode, so no req-to-strobe path exists.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [19:0] addr0,
  input  logic [15:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        we1,
  input  logic [19:0] addr1,
  input  logic [15:0] wdata1,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        grant,
  output logic        busy,
  output logic [19:0] SRAM_ADDR,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic        UB_N,
  output logic        LB_N,
  output logic [15:0] Data_write,
  input  logic [15:0] Data_read,
  output logic        Data_oe
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        bl_n_q, bl_n_d;
  logic        doe_q, doe_d;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not own the previous transaction wins.
          grant_d = (req0 && req1) ? ~last_grant_q : req1;
          we_d    = grant_d ? we1    : we0;
          addr_d  = grant_d ? addr1  : addr0;
          wdata_d = grant_d ? wdata1 : wdata0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = Data_read;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ce_n_d = 1'b1;
    oe_n_d = 1'b1;
    we_n_d = 1'b1;
    bl_n_d = 1'b1;
    doe_d  = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;

    // Strobes follow the state being entered; DONE keeps CE and the data drive for write hold.
    case (state_d)
      SETUP: begin
        ce_n_d = 1'b0;
        bl_n_d = 1'b0;
        oe_n_d = we_d;
        doe_d  = we_d;
      end
      ACCESS: begin
        ce_n_d = 1'b0;
        bl_n_d = 1'b0;
        oe_n_d = we_d;
        we_n_d = ~we_d;
        doe_d  = we_d;
      end
      DONE: begin
        ce_n_d = 1'b0;
        bl_n_d = 1'b0;
        doe_d  = we_d;
        ack0_d = ~grant_d;
        ack1_d = grant_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= 20'h0;
      wdata_q      <= 16'h0;
      cnt_q        <= 4'd0;
      rdata_q      <= 16'h0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      bl_n_q       <= 1'b1;
      doe_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      bl_n_q       <= bl_n_d;
      doe_q        <= doe_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata      = rdata_q;
  assign grant      = grant_q;
  assign busy       = (state_q != IDLE);
  assign SRAM_ADDR  = addr_q;
  assign CE_N       = ce_n_q;
  assign OE_N       = oe_n_q;
  assign WE_N       = we_n_q;
  assign UB_N       = bl_n_q;
  assign LB_N       = bl_n_q;
  assign Data_write = wdata_q;
  assign Data_oe    = doe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM model, transaction scoreboard and per-scenario tasks.
// A second instance built with WAIT_CYCLES=1 covers the short-access configuration.
module tb_sram_arbiter;

  logic        Clk;
  logic        Reset;
  logic        req0, we0, req1, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, grant, busy;
  logic [15:0] rdata;
  logic [19:0] SRAM_ADDR;
  logic        CE_N, OE_N, WE_N, UB_N, LB_N, Data_oe;
  logic [15:0] Data_write, Data_read;

  logic        b_req0, b_we0, b_ack0, b_ack1, b_grant, b_busy;
  logic [19:0] b_addr0, b_sram_addr;
  logic [15:0] b_wdata0, b_rdata, b_dwrite, b_dread;
  logic        b_ce_n, b_oe_n, b_we_n, b_ub_n, b_lb_n, b_doe;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [19:0] addr;
    logic [15:0] data;
  } txn_t;
  txn_t sb[$];

  logic [15:0] mem [0:255];
  logic        preload_en;
  logic [7:0]  preload_addr;
  logic [15:0] preload_data;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .grant(grant), .busy(busy), .SRAM_ADDR(SRAM_ADDR),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
    .Data_write(Data_write), .Data_read(Data_read), .Data_oe(Data_oe)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0),
    .req1(1'b0), .we1(1'b0), .addr1(20'h0), .wdata1(16'h0), .ack1(b_ack1),
    .rdata(b_rdata), .grant(b_grant), .busy(b_busy), .SRAM_ADDR(b_sram_addr),
    .CE_N(b_ce_n), .OE_N(b_oe_n), .WE_N(b_we_n), .UB_N(b_ub_n), .LB_N(b_lb_n),
    .Data_write(b_dwrite), .Data_read(b_dread), .Data_oe(b_doe)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM model: writes land on the clock edge while WE_N is low.
  always @(posedge Clk) begin
    if (preload_en) mem[preload_addr] <= preload_data;
    else if (!CE_N && !WE_N) mem[SRAM_ADDR[7:0]] <= Data_write;
  end
  assign Data_read = (!CE_N && !OE_N) ? mem[SRAM_ADDR[7:0]] : 16'h0000;
  assign b_dread   = (!b_ce_n && !b_oe_n) ? (b_sram_addr[15:0] ^ 16'hA5A5) : 16'h0000;

  always @(negedge Clk) begin
    if (Reset) begin
      if (ack0 || ack1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_ack ack0=%b ack1=%b required=no ack", ack0, ack1);
        end else begin
          txn_t e;
          logic [15:0] got;
          e = sb.pop_front();
          if ((ack0 && ack1) || grant !== e.port || (e.port ? !ack1 : !ack0)) begin
            failures++;
            $display("FAIL sb_port ack0=%b ack1=%b grant=%b required port=%0d", ack0, ack1, grant, e.port);
          end
          checks++;
          got = e.we ? mem[e.addr[7:0]] : rdata;
          if (got !== e.data) begin
            failures++;
            $display("FAIL sb_data we=%b addr=%h actual=%h required=%h", e.we, e.addr, got, e.data);
          end
        end
      end
      checks++;
      if (!OE_N && (Data_oe || !WE_N)) begin
        failures++;
        $display("FAIL bus_contention OE_N=%b WE_N=%b Data_oe=%b required OE_N low only alone", OE_N, WE_N, Data_oe);
      end
    end
  end

  task automatic pulse_reset();
    @(negedge Clk); Reset = 1'b0;
    @(negedge Clk); @(negedge Clk); Reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if ({CE_N, OE_N, WE_N, UB_N, LB_N, Data_oe, ack0, ack1, busy, grant} !== 10'b1111100000) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=1111100000",
               {CE_N, OE_N, WE_N, UB_N, LB_N, Data_oe, ack0, ack1, busy, grant});
    end
    checks++;
    if (rdata !== 16'h0 || SRAM_ADDR !== 20'h0 || Data_write !== 16'h0) begin
      failures++;
      $display("FAIL reset_data rdata=%h addr=%h dwrite=%h required=0", rdata, SRAM_ADDR, Data_write);
    end
    Reset = 1'b1;
  endtask

  task automatic test_read0();
    int lat = 0; int oe_bad = 0; logic got = 1'b0; logic a1 = 1'b0;
    @(negedge Clk); preload_en = 1'b1; preload_addr = 8'h12; preload_data = 16'hBEEF;
    @(negedge Clk); preload_en = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00012; wdata0 = 16'h0;
    sb.push_back('{1'b0, 1'b0, 20'h00012, 16'hBEEF});
    // Cycle 0 is the IDLE cycle in which the request is sampled.
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge Clk);
      if (ack1) a1 = 1'b1;
      if (ack0) begin got = 1'b1; lat = c; end
      else if (OE_N !== 1'b0) oe_bad++;
    end
    req0 = 1'b0;
    checks++;
    if (!got || lat != 4) begin failures++; $display("FAIL read0_latency actual=%0d required=4", lat); end
    checks++;
    if (oe_bad != 0) begin failures++; $display("FAIL read0_oe cycles_high=%0d required=0", oe_bad); end
    checks++;
    if (rdata !== 16'hBEEF) begin failures++; $display("FAIL read0_rdata actual=%h required=beef", rdata); end
    @(negedge Clk);
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || a1) begin
      failures++;
      $display("FAIL read0_pulse ack0=%b busy=%b ack1_seen=%b required 0/0/0", ack0, busy, a1);
    end
  endtask

  task automatic test_write1();
    int lat = 0; int we_low = 0; int hold_bad = 0; int oe_bad = 0; logic got = 1'b0;
    @(negedge Clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00040; wdata1 = 16'h1234;
    sb.push_back('{1'b1, 1'b1, 20'h00040, 16'h1234});
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge Clk);
      if (WE_N === 1'b0) we_low++;
      if (OE_N !== 1'b1) oe_bad++;
      if (Data_oe !== 1'b1 || SRAM_ADDR !== 20'h00040) hold_bad++;
      if (ack1) begin got = 1'b1; lat = c; end
    end
    req1 = 1'b0;
    checks++;
    if (!got || lat != 4) begin failures++; $display("FAIL write1_latency actual=%0d required=4", lat); end
    checks++;
    if (we_low != 2) begin failures++; $display("FAIL write1_we_width actual=%0d required=2", we_low); end
    checks++;
    if (hold_bad != 0 || oe_bad != 0) begin
      failures++;
      $display("FAIL write1_hold addr_oe_bad=%0d oe_n_low=%0d required=0/0", hold_bad, oe_bad);
    end
    checks++;
    if (rdata !== 16'hBEEF) begin failures++; $display("FAIL write1_rdata_kept actual=%h required=beef", rdata); end
  endtask

  task automatic test_tie();
    int n = 0; logic order [2];
    pulse_reset();
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00012;
    req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00041; wdata1 = 16'h5678;
    sb.push_back('{1'b0, 1'b0, 20'h00012, 16'hBEEF});
    sb.push_back('{1'b1, 1'b1, 20'h00041, 16'h5678});
    for (int c = 0; c < 40 && n < 2; c++) begin
      @(negedge Clk);
      if (ack0) begin order[n] = 1'b0; n++; req0 = 1'b0; end
      if (ack1 && n < 2) begin order[n] = 1'b1; n++; req1 = 1'b0; end
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (n != 2 || order[0] !== 1'b0 || order[1] !== 1'b1) begin
      failures++;
      $display("FAIL tie_order acks=%0d first=%b second=%b required 2,0,1", n, order[0], order[1]);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0; int k0 = 0; int k1 = 0; int c = 0; int gbad = 0; int sbad = 0;
    logic g [6]; int t [6];
    @(negedge Clk);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) sb.push_back('{1'b0, 1'b1, 20'h00050 + 20'(i / 2), 16'hA000 + 16'(i / 2)});
      else            sb.push_back('{1'b1, 1'b0, 20'h00040, 16'h1234});
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00050; wdata0 = 16'hA000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00040;
    while (c < 80 && n < 6) begin
      @(negedge Clk); c++;
      if (ack0 || ack1) begin
        g[n] = ack1; t[n] = c; n++;
        if (ack0) begin
          k0++;
          if (k0 == 3) req0 = 1'b0;
          else begin addr0 = 20'h00050 + 20'(k0); wdata0 = 16'hA000 + 16'(k0); end
        end
        if (ack1) begin k1++; if (k1 == 3) req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (g[i] !== 1'(i % 2)) gbad++;
      if (i > 0 && t[i] - t[i-1] != 5) sbad++;
    end
    checks++;
    if (n != 6 || gbad != 0) begin failures++; $display("FAIL b2b_grants acks=%0d out_of_order=%0d required 6/0", n, gbad); end
    checks++;
    if (sbad != 0) begin failures++; $display("FAIL b2b_spacing bad_gaps=%0d required=0 (gap 5)", sbad); end
  endtask

  task automatic test_reset_abort();
    int lat = 0; logic got = 1'b0;
    @(negedge Clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00060; wdata0 = 16'h9999;
    repeat (2) @(negedge Clk);
    checks++;
    if (WE_N !== 1'b0 || Data_oe !== 1'b1) begin
      failures++;
      $display("FAIL abort_in_access WE_N=%b Data_oe=%b required 0/1", WE_N, Data_oe);
    end
    #2 Reset = 1'b0;
    req0 = 1'b0;
    #1;
    checks++;
    if (WE_N !== 1'b1 || CE_N !== 1'b1 || Data_oe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_async WE_N=%b CE_N=%b Data_oe=%b busy=%b required 1/1/0/0", WE_N, CE_N, Data_oe, busy);
    end
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00040;
    sb.push_back('{1'b1, 1'b0, 20'h00040, 16'h1234});
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge Clk);
      if (ack0) lat = -1;
      if (ack1) begin got = 1'b1; if (lat == 0) lat = c; end
    end
    req1 = 1'b0;
    checks++;
    if (!got || lat != 4) begin failures++; $display("FAIL abort_recover latency=%0d required=4", lat); end
  endtask

  task automatic test_wait1();
    int lat = 0; int addr_bad = 0; logic got = 1'b0;
    logic [15:0] exp_data;
    exp_data = 16'h007A ^ 16'hA5A5;
    @(negedge Clk);
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 20'h0007A;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge Clk);
      b_addr0 = 20'h00FFF;
      if (b_sram_addr !== 20'h0007A) addr_bad++;
      if (b_ack0) begin got = 1'b1; lat = c; end
    end
    b_req0 = 1'b0;
    checks++;
    if (!got || lat != 3) begin failures++; $display("FAIL wait1_latency actual=%0d required=3", lat); end
    checks++;
    if (addr_bad != 0) begin failures++; $display("FAIL wait1_addr_latched bad_cycles=%0d required=0", addr_bad); end
    checks++;
    if (b_rdata !== exp_data) begin failures++; $display("FAIL wait1_rdata actual=%h required=%h", b_rdata, exp_data); end
  endtask

  initial begin
    Reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 20'h0; wdata0 = 16'h0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 20'h0; wdata1 = 16'h0;
    b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = 20'h0; b_wdata0 = 16'h0;
    preload_en = 1'b0; preload_addr = 8'h0; preload_data = 16'h0;

    test_reset();
    test_read0();
    test_write1();
    test_tie();
    test_back_to_back();
    test_reset_abort();
    test_wait1();

    repeat (3) @(negedge Clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_pending outstanding=%0d required=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
